ym_mol_mor_accum: RTL

- Parametrised successor to the per-slot MOL/MOR output latch. Instead of presenting one channel's panned 9-bit sample per slot, it sums the panned channel outputs of a full frame (CH_COUNT slots) into one stereo sample, with selectable saturation or wrap at OUT_WIDTH.
- Completed frames go into a show-ahead FIFO with a valid/ready handshake. This lets an external audio sink or resampler consume mixed samples at its own pace.

---
 rtl/ym_mol_mor_accum.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ym_mol_mor_accum.sv
// Frame mixer for panned channel slots: sums CH_COUNT slots into one stereo
// sample, fits it to OUT_WIDTH and queues it in a show-ahead valid/ready FIFO.
module ym_mol_mor_accum #(
  parameter int CH_COUNT   = 6,
  parameter int IN_WIDTH   = 9,
  parameter int OUT_WIDTH  = 12,
  parameter int SATURATE   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 MCLK,
  input  logic                 IC,
  input  logic                 ch_strobe,
  input  logic                 frame_sync,
  input  logic [IN_WIDTH-1:0]  ch_out,
  input  logic [1:0]           ch_pan,
  output logic [OUT_WIDTH-1:0] sample_l,
  output logic [OUT_WIDTH-1:0] sample_r,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 frame_err,
  output logic                 ovf,
  input  logic                 clr_ovf
);
  localparam int ACC_W = IN_WIDTH + $clog2(CH_COUNT) + 1;
  localparam int CNT_W = $clog2(CH_COUNT + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CH_COUNT);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_PUSH} state_e;
  typedef struct packed {
    logic [OUT_WIDTH-1:0] l;
    logic [OUT_WIDTH-1:0] r;
  } stereo_t;

  // A single-slot frame is complete as soon as it starts.
  localparam state_e S_START = (CH_COUNT == 1) ? S_PUSH : S_ACCUM;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d, con_l, con_r;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    frame_err_q, frame_err_d, ovf_q, ovf_d;
  logic                    push, start, cont;
  logic signed [IN_WIDTH-1:0] ch_s;

  assign start = ch_strobe & frame_sync;
  assign cont  = ch_strobe & ~frame_sync;
  assign ch_s  = {~ch_out[IN_WIDTH-1], ch_out[IN_WIDTH-2:0]};
  assign con_l = ch_pan[1] ? ACC_W'(ch_s) : '0;
  assign con_r = ch_pan[0] ? ACC_W'(ch_s) : '0;

  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_START;
      S_ACCUM: if (start) state_d = S_ACCUM;
               else if (cont && (cnt_q + CNT_W'(1)) == CNT_LAST) state_d = S_PUSH;
      S_PUSH:  state_d = start ? S_START : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    cnt_d       = cnt_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        acc_l_d = con_l; acc_r_d = con_r; cnt_d = CNT_W'(1);
      end
      S_ACCUM: if (start) begin
        acc_l_d = con_l; acc_r_d = con_r; cnt_d = CNT_W'(1); frame_err_d = 1'b1;
      end else if (cont) begin
        acc_l_d = acc_l_q + con_l; acc_r_d = acc_r_q + con_r; cnt_d = cnt_q + CNT_W'(1);
      end
      S_PUSH: begin
        push = 1'b1;
        if (start) begin
          acc_l_d = con_l; acc_r_d = con_r; cnt_d = CNT_W'(1);
        end else if (cont) frame_err_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      acc_l_q <= '0; acc_r_q <= '0; cnt_q <= '0; frame_err_q <= 1'b0;
    end else begin
      acc_l_q <= acc_l_d; acc_r_q <= acc_r_d; cnt_q <= cnt_d; frame_err_q <= frame_err_d;
    end
  end

  // Fit the sums to OUT_WIDTH: clamp or wrap when narrower, sign-extend otherwise.
  logic [OUT_WIDTH-1:0] res_l, res_r;
  if (ACC_W > OUT_WIDTH) begin : g_narrow
    localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OMIN = ~OMAX;
    function automatic logic [OUT_WIDTH-1:0] fit(input logic signed [ACC_W-1:0] a);
      if (SATURATE != 0 && a > OMAX) return OMAX[OUT_WIDTH-1:0];
      if (SATURATE != 0 && a < OMIN) return OMIN[OUT_WIDTH-1:0];
      return a[OUT_WIDTH-1:0];
    endfunction
    assign res_l = fit(acc_l_q);
    assign res_r = fit(acc_r_q);
  end else begin : g_wide
    assign res_l = OUT_WIDTH'(acc_l_q);
    assign res_r = OUT_WIDTH'(acc_r_q);
  end

  stereo_t          mem_q [FIFO_DEPTH];
  stereo_t          head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic             full, pop, wr, drop;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    full     = (fcnt_q == FC_W'(FIFO_DEPTH));
    pop      = sample_valid & sample_ready;
    wr       = push & (~full | pop);
    drop     = push & full & ~pop;
    wr_ptr_d = wr  ? nxt(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? nxt(rd_ptr_q) : rd_ptr_q;
    fcnt_d   = fcnt_q;
    if (wr && !pop)      fcnt_d = fcnt_q + FC_W'(1);
    else if (!wr && pop) fcnt_d = fcnt_q - FC_W'(1);
    // A fresh drop outranks a clear arriving in the same cycle.
    ovf_d    = (ovf_q & ~clr_ovf) | drop;
  end

  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0; rd_ptr_q <= '0; fcnt_q <= '0; ovf_q <= 1'b0;
    end else begin
      if (wr) mem_q[wr_ptr_q] <= '{l: res_l, r: res_r};
      wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; fcnt_q <= fcnt_d; ovf_q <= ovf_d;
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign sample_valid = (fcnt_q != '0);
  assign sample_l     = sample_valid ? head.l : '0;
  assign sample_r     = sample_valid ? head.r : '0;
  assign frame_err    = frame_err_q;
  assign ovf          = ovf_q;
endmodule
